// File: rtl/cpu4_dmem_resp_if.sv
// Load/store bus between the cpu4 datapath (master) and its data memory (slave).
// The request and response channels each use their own valid/ready handshake.
interface cpu4_dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/cpu4_dmem_resp.sv
// Data-memory responder for cpu4: accepts one request at a time, inserts WAIT
// wait states, does a byte-enabled word access, then holds the response until taken.
module cpu4_dmem_resp #(
  parameter int AW   = 8,
  parameter int WAIT = 2
) (
  input logic           clk,
  input logic           reset,
  cpu4_dmem_resp_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [0:(1 << AW) - 1];

  logic          accept;
  logic          do_access;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  // With zero wait states the access happens at the accepting edge, so it must
  // use the live request instead of the captured copy.
  assign acc_we    = (state == IDLE) ? bus.req_we    : we_q;
  assign acc_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
  assign acc_be    = (state == IDLE) ? bus.req_be    : be_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);

  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT == 0) begin
            do_access  = 1'b1;
            next_state = RESP;
          end else begin
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          do_access  = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset aborts everything, including a store that would commit this edge.
    if (reset) begin
      accept    = 1'b0;
      do_access = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
        cnt     <= WAIT_INIT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rdata_q <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
        err_q   <= acc_err;
      end else if (state == RESP && bus.rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Memory contents survive reset by design.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
